axis_pkt_gen: RTL and testbench

//  AXI-Stream master (transmitter) that turns one command into one packet of incrementing data beats with TLAST.

---
 rtl/axis_pkg.sv | 14 +
 rtl/axis_pkt_gen_if.sv | 33 +++
 rtl/axis_pkt_gen.sv | 154 +++++++++++++++
 tb/tb_axis_pkt_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXIS definitions: FSM state encodings and default widths.
// Imported by the packet generator and its interface users.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int AXIS_DATA_WIDTH = 8;
  localparam int AXIS_LEN_WIDTH  = 8;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// Command + AXI-Stream bundle for axis_pkt_gen.
// master: generator side (drives cmd_ready, m_t*, busy); slave: user side.
interface axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] cmd_seed;
  logic [DATA_WIDTH-1:0] cmd_step;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, cmd_step,
    input  m_tready,
    output cmd_ready, m_tdata, m_tvalid, m_tlast,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_seed, cmd_step,
    output m_tready,
    input  cmd_ready, m_tdata, m_tvalid, m_tlast,
    input  busy
  );

endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: one command -> cmd_len+1 beats of
// seed, seed+step, ... with TLAST on the final beat, then GAP_CYCLES idle.
// Ports: aclk, areset (async, active-high), bus (axis_pkt_gen_if.master:
//   cmd_valid/ready/len/seed/step, m_tdata/tvalid/tready/tlast, busy).
// Optional: AXIS_PKT_GEN_STATS_EN adds pkt_cnt[31:0] and beat_cnt[31:0].
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int LEN_WIDTH  = AXIS_LEN_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic          aclk,
  input  logic          areset,
  axis_pkt_gen_if.master bus
`ifdef AXIS_PKT_GEN_STATS_EN
  ,
  output logic [31:0]   pkt_cnt,
  output logic [31:0]   beat_cnt
`endif
);

  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  cmd_rdy;
  logic                  cmd_fire;
  logic                  beat_acc;
  logic [LEN_WIDTH-1:0]  beat_nxt;

  assign cmd_rdy  = (state_q == IDLE) & ~areset;
  assign cmd_fire = bus.cmd_valid & cmd_rdy;
  assign beat_acc = valid_q & bus.m_tready;
  assign beat_nxt = beat_q + LEN_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    step_d  = step_q;
    len_d   = len_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = SEND;
          data_d  = bus.cmd_seed;
          step_d  = bus.cmd_step;
          len_d   = bus.cmd_len;
          beat_d  = '0;
          valid_d = 1'b1;
          last_d  = (bus.cmd_len == '0);
        end
      end
      SEND: begin
        if (beat_acc) begin
          data_d = data_q + step_q;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            beat_d  = '0;
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            beat_d = beat_nxt;
            // tlast is registered one beat ahead
            last_d = (beat_nxt == len_q);
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      data_q  <= '0;
      step_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      step_q  <= step_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.m_tdata   = data_q;
  assign bus.m_tvalid  = valid_q;
  assign bus.m_tlast   = last_q;
  assign bus.busy      = (state_q == SEND)
                       | (state_q == GAP);

`ifdef AXIS_PKT_GEN_STATS_EN
  logic [31:0] pkt_q, pkt_d;
  logic [31:0] bcnt_q, bcnt_d;

  always_comb begin
    pkt_d  = pkt_q;
    bcnt_d = bcnt_q;
    if (beat_acc) begin
      bcnt_d = bcnt_q + 32'd1;
      if (last_q) begin
        pkt_d = pkt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_q  <= '0;
      bcnt_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign pkt_cnt  = pkt_q;
  assign beat_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: two instances (GAP_CYCLES 0 and 3)
// compared every cycle against a beat-queue model, plus literal checks.
module tb_axis_pkt_gen;

  localparam int DW = 8;
  localparam int LW = 8;

  typedef struct packed {
    logic [7:0] len;
    logic [7:0] seed;
    logic [7:0] step;
  } cmd_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;

  cmd_t  cmdq [2][$];
  beat_t expq [2][$];
  beat_t logq [2][$];
  int    logc [2][$];
  int    last_cyc [2][$];
  int    cmd_cyc [2][$];
  int    gap_left [2];
  bit    acc [2];
  int    cyc [2];
  longint exp_pkt [2];
  longint exp_beat [2];
  beat_t want [$];

  function automatic void chk(string nm, int g,
                              logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t",
               nm, g, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int GAPC = (g == 0) ? 0 : 3;

    axis_pkt_gen_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] beat_cnt;
`endif

    axis_pkt_gen #(
      .DATA_WIDTH(DW),
      .LEN_WIDTH(LW),
      .GAP_CYCLES(GAPC)
    ) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus)
`ifdef AXIS_PKT_GEN_STATS_EN
      ,
      .pkt_cnt(pkt_cnt),
      .beat_cnt(beat_cnt)
`endif
    );

    // stimulus driver: commands from cmdq, tready by mode
    initial begin
      int k;
      k = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_seed  = '0;
      bus.cmd_step  = '0;
      bus.m_tready  = 1'b0;
      forever begin
        @(posedge aclk);
        #1;
        k++;
        if (areset) begin
          bus.cmd_valid = 1'b0;
          cmdq[g].delete();
        end else begin
          if (bus.cmd_valid && acc[g]) begin
            cmdq[g].delete(0);
            bus.cmd_valid = 1'b0;
          end
          if (!bus.cmd_valid) begin
            if (cmdq[g].size() > 0 &&
                (rdy_mode != 2 || $urandom_range(0, 2) == 0)) begin
              bus.cmd_valid = 1'b1;
              {bus.cmd_len, bus.cmd_seed, bus.cmd_step} = cmdq[g][0];
            end else begin
              bus.cmd_len  = 8'($urandom);
              bus.cmd_seed = 8'($urandom);
              bus.cmd_step = 8'($urandom);
            end
          end
        end
        acc[g] = 1'b0;
        case (rdy_mode)
          0:       bus.m_tready = 1'b1;
          1:       bus.m_tready = (k % 3 == 0);
          default: bus.m_tready = 1'($urandom_range(0, 1));
        endcase
      end
    end

    // model + compare, sampled on the falling edge
    initial begin
      bit    rdy_e;
      cmd_t  c;
      beat_t b;
      cyc[g] = 0;
      gap_left[g] = 0;
      exp_pkt[g] = 0;
      exp_beat[g] = 0;
      forever begin
        @(negedge aclk);
        if (areset) begin
          chk("rst_tvalid", g, bus.m_tvalid, 0);
          chk("rst_tlast", g, bus.m_tlast, 0);
          chk("rst_tdata", g, bus.m_tdata, 0);
          chk("rst_cmd_ready", g, bus.cmd_ready, 0);
          chk("rst_busy", g, bus.busy, 0);
          expq[g].delete();
          gap_left[g] = 0;
          exp_pkt[g] = 0;
          exp_beat[g] = 0;
`ifdef AXIS_PKT_GEN_STATS_EN
          chk("rst_pkt_cnt", g, pkt_cnt, 0);
          chk("rst_beat_cnt", g, beat_cnt, 0);
`endif
        end else begin
          rdy_e = (expq[g].size() == 0) && (gap_left[g] == 0);
          chk("cmd_ready", g, bus.cmd_ready, rdy_e);
          chk("busy", g, bus.busy,
              (expq[g].size() > 0) || (gap_left[g] > 0));
          chk("tvalid", g, bus.m_tvalid, expq[g].size() > 0);
          if (expq[g].size() > 0 && bus.m_tvalid) begin
            chk("tdata", g, bus.m_tdata, expq[g][0].d);
            chk("tlast", g, bus.m_tlast, expq[g][0].l);
          end
`ifdef AXIS_PKT_GEN_STATS_EN
          chk("pkt_cnt", g, pkt_cnt, exp_pkt[g][31:0]);
          chk("beat_cnt", g, beat_cnt, exp_beat[g][31:0]);
`endif
          if (gap_left[g] > 0) gap_left[g]--;
          if (expq[g].size() > 0 && bus.m_tvalid && bus.m_tready) begin
            b = expq[g].pop_front();
            logq[g].push_back(b);
            logc[g].push_back(cyc[g]);
            exp_beat[g]++;
            if (b.l) begin
              exp_pkt[g]++;
              gap_left[g] = GAPC;
              last_cyc[g].push_back(cyc[g]);
            end
          end
          if (bus.cmd_valid && rdy_e) begin
            c = {bus.cmd_len, bus.cmd_seed, bus.cmd_step};
            for (int i = 0; i <= int'(c.len); i++) begin
              b.d = 8'(int'(c.seed) + i * int'(c.step));
              b.l = (i == int'(c.len));
              expq[g].push_back(b);
            end
            acc[g] = 1'b1;
            cmd_cyc[g].push_back(cyc[g]);
          end
        end
        cyc[g]++;
      end
    end
  end

  function automatic cmd_t mk(int len, int seed, int step);
    cmd_t c;
    c.len = 8'(len);
    c.seed = 8'(seed);
    c.step = 8'(step);
    return c;
  endfunction

  function automatic void w(int d, bit l);
    beat_t b;
    b.d = 8'(d);
    b.l = l;
    want.push_back(b);
  endfunction

  function automatic void clr(int g);
    logq[g].delete();
    logc[g].delete();
    last_cyc[g].delete();
    cmd_cyc[g].delete();
    want.delete();
  endfunction

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (n < budget &&
           !(cmdq[0].size() == 0 && cmdq[1].size() == 0 &&
             expq[0].size() == 0 && expq[1].size() == 0 &&
             gap_left[0] == 0 && gap_left[1] == 0 &&
             !u[0].bus.cmd_valid && !u[1].bus.cmd_valid)) begin
      @(posedge aclk);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL wait_idle timeout after %0d cycles", n);
    end
    repeat (2) @(posedge aclk);
  endtask

  task automatic check_log(int g, string nm);
    chk({nm, "_count"}, g, logq[g].size(), want.size());
    foreach (want[i]) begin
      if (i < logq[g].size()) chk(nm, g, logq[g][i], want[i]);
    end
  endtask

  initial begin
    int n;
    cmd_t c;

    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("init_cmd_ready", 0, u[0].bus.cmd_ready, 0);
    chk("init_tvalid", 1, u[1].bus.m_tvalid, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_ready", 0, u[0].bus.cmd_ready, 1);
    chk("post_rst_busy", 0, u[0].bus.busy, 0);

    // 1: four beats at full throughput
    clr(0);
    cmdq[0].push_back(mk(3, 8'h10, 1));
    wait_idle(200);
    w(8'h10, 0); w(8'h11, 0); w(8'h12, 0); w(8'h13, 1);
    check_log(0, "t1_beats");
    if (logc[0].size() == 4)
      chk("t1_no_bubble", 0, logc[0][3] - logc[0][0], 3);

    // 2: stalled sink
    rdy_mode = 1;
    clr(0);
    cmdq[0].push_back(mk(3, 8'h10, 1));
    wait_idle(200);
    w(8'h10, 0); w(8'h11, 0); w(8'h12, 0); w(8'h13, 1);
    check_log(0, "t2_beats");
    rdy_mode = 0;

    // 3: single-beat packet and wrap, back to back
    clr(0);
    cmdq[0].push_back(mk(0, 8'hFF, 1));
    cmdq[0].push_back(mk(2, 8'hFE, 1));
    wait_idle(200);
    w(8'hFF, 1); w(8'hFE, 0); w(8'hFF, 0); w(8'h00, 1);
    check_log(0, "t3_beats");
    chk("t3_cmds", 0, cmd_cyc[0].size(), 2);
    if (cmd_cyc[0].size() == 2 && last_cyc[0].size() > 0)
      chk("t3_b2b", 0, cmd_cyc[0][1] - last_cyc[0][0], 1);

    // 4: three-cycle gap
    clr(1);
    cmdq[1].push_back(mk(3, 8'h10, 1));
    cmdq[1].push_back(mk(1, 8'h20, 1));
    wait_idle(200);
    w(8'h10, 0); w(8'h11, 0); w(8'h12, 0); w(8'h13, 1);
    w(8'h20, 0); w(8'h21, 1);
    check_log(1, "t4_beats");
    chk("t4_cmds", 1, cmd_cyc[1].size(), 2);
    if (cmd_cyc[1].size() == 2 && last_cyc[1].size() > 0)
      chk("t4_gap", 1, cmd_cyc[1][1] - last_cyc[1][0], 4);

    // random traffic on both instances, incl. max length
    rdy_mode = 2;
    cmdq[0].push_back(mk(255, $urandom, 1));
    for (int i = 0; i < 30; i++) begin
      for (int g = 0; g < 2; g++) begin
        c = mk($urandom_range(0, 12), $urandom, $urandom);
        cmdq[g].push_back(c);
      end
    end
    wait_idle(20000);
    rdy_mode = 0;

    // 5: reset during beat 2 of 6
    clr(0);
    cmdq[0].push_back(mk(5, 8'h40, 3));
    n = 0;
    do begin
      @(posedge aclk);
      n++;
    end while (logq[0].size() < 2 && n < 100);
    chk("t5_reach_beat2", 0, logq[0].size(), 2);
    #1;
    areset = 1'b1;
    #1;
    chk("t5_drop_tvalid", 0, u[0].bus.m_tvalid, 0);
    chk("t5_drop_busy", 0, u[0].bus.busy, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("t5_ready", 0, u[0].bus.cmd_ready, 1);
    clr(0);
    cmdq[0].push_back(mk(1, 8'h70, 2));
    wait_idle(200);
    w(8'h70, 0); w(8'h72, 1);
    check_log(0, "t5_beats");

`ifdef AXIS_PKT_GEN_STATS_EN
    // 6: counters over five 4-beat packets
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 5; i++) cmdq[0].push_back(mk(3, $urandom, 1));
    wait_idle(500);
    chk("t6_pkt_cnt", 0, u[0].pkt_cnt, 5);
    chk("t6_beat_cnt", 0, u[0].beat_cnt, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
